// File: rtl/scroll_sprite_renderer_pkg.sv
// Shared encodings and constants for the scrolling background and sprite renderer.
package scroll_sprite_renderer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BG,
      S_SPR,
      S_WAIT,
      S_UPDATE
   } state_t;

   typedef enum logic [1:0] {
      J_GROUND,
      J_RISE,
      J_FALL
   } jump_t;

   localparam int unsigned TRANSP_DEFAULT = 0;
   localparam int unsigned COLOUR_BLANK   = 0;

   // Width helper that never yields a zero-width vector.
   function automatic int unsigned safe_clog2(input int unsigned v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Column-major-inner raster scan counter; advances one position per enabled cycle and wraps.
module raster_counter
   import scroll_sprite_renderer_pkg::*;
#(
   parameter int unsigned W = 8,
   parameter int unsigned H = 8,
   localparam int unsigned CW = safe_clog2(W),
   localparam int unsigned RW = safe_clog2(H)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          enable,
   input  logic          clear,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic          last
);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         col <= '0;
         row <= '0;
      end else if (clear) begin
         col <= '0;
         row <= '0;
      end else if (enable) begin
         if (col == CW'(W - 1)) begin
            col <= '0;
            row <= (row == RW'(H - 1)) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   assign last = (col == CW'(W - 1)) && (row == RW'(H - 1));

endmodule

// File: rtl/scroll_sprite_renderer.sv
// Draws a horizontally scrolling background window and a jumping sprite, one pixel per cycle,
// then waits for a frame tick to advance scroll and jump height.
module scroll_sprite_renderer
   import scroll_sprite_renderer_pkg::*;
#(
   parameter int unsigned SCR_W       = 160,
   parameter int unsigned SCR_H       = 120,
   parameter int unsigned BG_W        = 2000,
   parameter int unsigned SPR_W       = 15,
   parameter int unsigned SPR_H       = 16,
   parameter int unsigned SPR_X       = 20,
   parameter int unsigned GROUND_Y    = 24,
   parameter int unsigned JUMP_H      = 20,
   parameter int unsigned SCROLL_STEP = 1,
   parameter int unsigned COL_W       = 3,
   parameter int unsigned TRANSP      = TRANSP_DEFAULT,
   localparam int unsigned BGA_W = safe_clog2(BG_W * SCR_H),
   localparam int unsigned SPA_W = safe_clog2(SPR_W * SPR_H),
   localparam int unsigned X_W   = safe_clog2(SCR_W),
   localparam int unsigned Y_W   = safe_clog2(SCR_H)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             tick,
   input  logic             jump,
   output logic [BGA_W-1:0] bg_addr,
   input  logic [COL_W-1:0] bg_data,
   output logic [SPA_W-1:0] spr_addr,
   input  logic [COL_W-1:0] spr_data,
   output logic [X_W-1:0]   x,
   output logic [Y_W-1:0]   y,
   output logic [COL_W-1:0] colour,
   output logic             plot,
   output logic             busy,
   output logic             frame_done
);

   localparam int unsigned SC_W  = safe_clog2(BG_W);
   localparam int unsigned SS_W  = safe_clog2(2 * BG_W);
   localparam int unsigned CS_W  = safe_clog2(BG_W + SCR_W);
   localparam int unsigned H_W   = safe_clog2(JUMP_H + 1);
   localparam int unsigned SCW_W = safe_clog2(SPR_W);
   localparam int unsigned SRW_W = safe_clog2(SPR_H);

   if (SPR_X + SPR_W > SCR_W) begin : g_bad_spr_x
      $error("sprite extends past right screen edge");
   end
   if (GROUND_Y + SPR_H > SCR_H) begin : g_bad_spr_y
      $error("grounded sprite extends past bottom screen edge");
   end
   if (JUMP_H > GROUND_Y) begin : g_bad_jump
      $error("jump height exceeds ground row");
   end
   if (SCROLL_STEP >= BG_W) begin : g_bad_step
      $error("scroll step must be smaller than background width");
   end

   state_t state, state_nxt;
   jump_t  jstate;

   logic [SC_W-1:0]  scroll;
   logic [SS_W-1:0]  scroll_sum;
   logic [SC_W-1:0]  scroll_nxt;
   logic [H_W-1:0]   height;
   logic             tick_pend;
   logic             jump_req;
   logic [CS_W-1:0]  col_sum;

   logic [X_W-1:0]   bg_col;
   logic [Y_W-1:0]   bg_row;
   logic             bg_last;
   logic [SCW_W-1:0] spr_col;
   logic [SRW_W-1:0] spr_row;
   logic             spr_last;

   logic             bg_v;
   logic             spr_v;

   raster_counter #(.W(SCR_W), .H(SCR_H)) u_bg_scan (
      .clk    (clk),
      .resetn (resetn),
      .enable (state == S_BG),
      .clear  (state == S_IDLE),
      .col    (bg_col),
      .row    (bg_row),
      .last   (bg_last)
   );

   raster_counter #(.W(SPR_W), .H(SPR_H)) u_spr_scan (
      .clk    (clk),
      .resetn (resetn),
      .enable (state == S_SPR),
      .clear  (state == S_IDLE),
      .col    (spr_col),
      .row    (spr_row),
      .last   (spr_last)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start)     state_nxt = S_BG;
         S_BG:     if (bg_last)   state_nxt = S_SPR;
         S_SPR:    if (spr_last)  state_nxt = S_WAIT;
         S_WAIT:   if (tick_pend) state_nxt = S_UPDATE;
         S_UPDATE: state_nxt = S_BG;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == S_BG) || (state == S_SPR) || (state == S_UPDATE);
      bg_addr  = '0;
      spr_addr = '0;
      // scroll < BG_W and col < SCR_W, so one subtract completes the modulo.
      col_sum  = CS_W'(bg_col) + CS_W'(scroll);
      if (col_sum >= CS_W'(BG_W)) col_sum = col_sum - CS_W'(BG_W);
      if (state == S_BG)
         bg_addr = BGA_W'(bg_row) * BGA_W'(BG_W) + BGA_W'(col_sum);
      if (state == S_SPR)
         spr_addr = SPA_W'(spr_row) * SPA_W'(SPR_W) + SPA_W'(spr_col);
      colour = COL_W'(COLOUR_BLANK);
      if (bg_v)       colour = bg_data;
      else if (spr_v) colour = spr_data;
      plot = bg_v || (spr_v && (spr_data != COL_W'(TRANSP)));
   end

   // Coordinates trail the address by one cycle to line up with ROM data.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bg_v       <= 1'b0;
         spr_v      <= 1'b0;
         x          <= '0;
         y          <= '0;
         frame_done <= 1'b0;
      end else begin
         bg_v       <= (state == S_BG);
         spr_v      <= (state == S_SPR);
         frame_done <= (state == S_SPR) && spr_last;
         if (state == S_BG) begin
            x <= bg_col;
            y <= bg_row;
         end else if (state == S_SPR) begin
            x <= X_W'(SPR_X) + X_W'(spr_col);
            y <= Y_W'(GROUND_Y) - Y_W'(height) + Y_W'(spr_row);
         end else begin
            x <= '0;
            y <= '0;
         end
      end
   end

   always_comb begin
      scroll_sum = SS_W'(scroll) + SS_W'(SCROLL_STEP);
      if (scroll_sum >= SS_W'(BG_W)) scroll_sum = scroll_sum - SS_W'(BG_W);
      scroll_nxt = SC_W'(scroll_sum);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         scroll    <= '0;
         height    <= '0;
         jstate    <= J_GROUND;
         tick_pend <= 1'b0;
         jump_req  <= 1'b0;
      end else begin
         if (state == S_IDLE)                  tick_pend <= 1'b0;
         else if (state == S_WAIT && tick_pend) tick_pend <= tick;
         else if (tick)                         tick_pend <= 1'b1;

         if (state == S_UPDATE)                   jump_req <= 1'b0;
         else if (jump && (jstate == J_GROUND))   jump_req <= 1'b1;

         if (state == S_UPDATE) begin
            scroll <= scroll_nxt;
            case (jstate)
               J_GROUND: begin
                  if (jump_req && (JUMP_H != 0)) begin
                     height <= H_W'(1);
                     jstate <= (JUMP_H == 1) ? J_FALL : J_RISE;
                  end
               end
               J_RISE: begin
                  height <= height + 1'b1;
                  if (height == H_W'(JUMP_H - 1)) jstate <= J_FALL;
               end
               J_FALL: begin
                  height <= height - 1'b1;
                  if (height == H_W'(1)) jstate <= J_GROUND;
               end
               default: jstate <= J_GROUND;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_scroll_sprite_renderer.sv
// Directed bench for scroll_sprite_renderer using a reduced screen so many frames fit in a short run.
module tb_scroll_sprite_renderer;

   localparam int unsigned SCR_W       = 10;
   localparam int unsigned SCR_H       = 8;
   localparam int unsigned BG_W        = 13;
   localparam int unsigned SPR_W       = 3;
   localparam int unsigned SPR_H       = 3;
   localparam int unsigned SPR_X       = 6;
   localparam int unsigned GROUND_Y    = 5;
   localparam int unsigned JUMP_H      = 4;
   localparam int unsigned SCROLL_STEP = 1;
   localparam int unsigned COL_W       = 3;
   localparam int unsigned NBG         = SCR_W * SCR_H;
   localparam int unsigned NSP         = SPR_W * SPR_H;

   logic       clk = 1'b0;
   logic       resetn, start, tick, jump;
   logic [6:0] bg_addr;
   logic [2:0] bg_data, spr_data, colour;
   logic [3:0] spr_addr, x;
   logic [2:0] y;
   logic       plot, busy, frame_done;

   logic [2:0] spr_mem [0:15];
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned scr, h;

   scroll_sprite_renderer #(
      .SCR_W(SCR_W), .SCR_H(SCR_H), .BG_W(BG_W), .SPR_W(SPR_W), .SPR_H(SPR_H),
      .SPR_X(SPR_X), .GROUND_Y(GROUND_Y), .JUMP_H(JUMP_H),
      .SCROLL_STEP(SCROLL_STEP), .COL_W(COL_W), .TRANSP(0)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start), .tick(tick), .jump(jump),
      .bg_addr(bg_addr), .bg_data(bg_data), .spr_addr(spr_addr), .spr_data(spr_data),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] bg_rom(input int unsigned a);
      return 3'((a * 5 + 3) % 8);
   endfunction

   always @(posedge clk) begin
      bg_data  <= bg_rom(int'(bg_addr));
      spr_data <= spr_mem[spr_addr];
   end

   function automatic int unsigned exp_bg(input int unsigned k, input int unsigned s);
      return (k / SCR_W) * BG_W + ((s + (k % SCR_W)) % BG_W);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bg_px(input int unsigned k, input int unsigned s);
      chk("bg_plot", plot, 1);
      chk("bg_x", x, k % SCR_W);
      chk("bg_y", y, k / SCR_W);
      chk("bg_colour", colour, bg_rom(exp_bg(k, s)));
   endtask

   task automatic chk_spr_px(input int unsigned i, input int unsigned hh);
      chk("spr_x", x, SPR_X + i % SPR_W);
      chk("spr_y", y, GROUND_Y - hh + i / SPR_W);
      chk("spr_colour", colour, spr_mem[i]);
      chk("spr_plot", plot, spr_mem[i] != 3'd0);
   endtask

   // Entered on the first BG cycle; leaves on the WAIT entry cycle.
   task automatic check_frame(input int unsigned s, input int unsigned hh, input int unsigned nticks);
      for (int unsigned k = 0; k < NBG; k++) begin
         chk("bg_addr", bg_addr, exp_bg(k, s));
         chk("busy_bg", busy, 1);
         if (k == 0) begin
            chk("plot_first", plot, 0);
            chk("frame_done_bg", frame_done, 0);
         end else begin
            chk_bg_px(k - 1, s);
         end
         tick = (k < 3 * nticks) && (k % 3 == 2);
         step;
         tick = 1'b0;
      end
      for (int unsigned i = 0; i < NSP; i++) begin
         chk("spr_addr", spr_addr, i);
         if (i == 0) chk_bg_px(NBG - 1, s);
         else        chk_spr_px(i - 1, hh);
         step;
      end
      chk_spr_px(NSP - 1, hh);
      chk("frame_done", frame_done, 1);
      chk("busy_wait", busy, 0);
   endtask

   task automatic tick_frame(input int unsigned s, input int unsigned hh, input int unsigned nticks);
      tick = 1'b1;
      step;
      tick = 1'b0;
      chk("busy_wait_pend", busy, 0);
      step;
      chk("busy_update", busy, 1);
      chk("plot_update", plot, 0);
      step;
      check_frame(s, hh, nticks);
      step;
      chk("frame_done_pulse", frame_done, 0);
   endtask

   initial begin
      resetn = 1'b0;
      start  = 1'b0;
      tick   = 1'b0;
      jump   = 1'b0;
      for (int i = 0; i < 16; i++) spr_mem[i] = 3'((i % 7) + 1);
      spr_mem[0] = 3'd0;
      spr_mem[4] = 3'd0;
      #2;
      chk("rst_plot", plot, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_colour", colour, 0);
      chk("rst_bg_addr", bg_addr, 0);
      chk("rst_spr_addr", spr_addr, 0);
      step;
      resetn = 1'b1;
      step;

      // Tick while idle is discarded.
      tick = 1'b1;
      step;
      tick = 1'b0;
      step;
      chk("idle_busy", busy, 0);

      start = 1'b1;
      step;
      start = 1'b0;
      scr = 0;
      check_frame(scr, 0, 0);
      step;
      chk("frame_done_one", frame_done, 0);
      chk("wait_no_tick", busy, 0);

      start = 1'b1;
      step;
      start = 1'b0;
      step;
      chk("start_ignored", busy, 0);
      chk("start_ignored_addr", bg_addr, 0);

      scr = 1;
      tick_frame(scr, 0, 0);
      chk("wait_after_tick", busy, 0);

      // Three ticks during BG merge into one update.
      scr = 2;
      tick_frame(scr, 0, 3);
      chk("merged_update", busy, 1);
      step;
      scr = 3;
      check_frame(scr, 0, 0);
      step;
      chk("merged_frame_done", frame_done, 0);
      step;
      step;
      chk("single_update", busy, 0);

      while (scr != BG_W - 1) begin
         scr++;
         tick_frame(scr, 0, 0);
      end
      chk("wrap_addr_col1", exp_bg(1, scr), 0);
      scr = 0;
      tick_frame(scr, 0, 0);

      jump = 1'b1;
      step;
      jump = 1'b0;
      for (int unsigned i = 1; i <= 2 * JUMP_H; i++) begin
         h = (i <= JUMP_H) ? i : 2 * JUMP_H - i;
         if (i == 2) begin
            jump = 1'b1;
            step;
            jump = 1'b0;
         end
         scr = (scr + SCROLL_STEP) % BG_W;
         tick_frame(scr, h, 0);
      end
      scr = (scr + SCROLL_STEP) % BG_W;
      tick_frame(scr, 0, 0);

      // Reset asserted mid-background, row 3.
      tick = 1'b1;
      step;
      tick = 1'b0;
      step;
      step;
      repeat (3 * SCR_W + 2) step;
      chk("mid_bg_busy", busy, 1);
      resetn = 1'b0;
      #1;
      chk("mid_rst_plot", plot, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_bg_addr", bg_addr, 0);
      chk("mid_rst_x", x, 0);
      chk("mid_rst_frame_done", frame_done, 0);
      step;
      resetn = 1'b1;
      step;
      chk("post_rst_idle", busy, 0);
      start = 1'b1;
      step;
      start = 1'b0;
      check_frame(0, 0, 0);
      step;
      chk("post_rst_frame_done", frame_done, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/scroll_sprite_renderer.md
SCROLL_SPRITE_RENDERER -- requirements
Module: scroll_sprite_renderer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): SCR_W 160 screen width px; SCR_H 120 screen height px; BG_W 2000 background width px; SPR_W 15 sprite width; SPR_H 16 sprite height; SPR_X 20 sprite left column; GROUND_Y 24 sprite top row when grounded; JUMP_H 20 max jump height px; SCROLL_STEP 1 px per tick; COL_W 3 colour bits; TRANSP 0 sprite colour key.
REQ-002 Ports SHALL be (name dir width meaning): clk in 1 system clock; resetn in 1 async active-low reset; start in 1 begin rendering; tick in 1 frame-rate enable pulse; jump in 1 jump request; bg_addr out clog2(BG_W*SCR_H) background ROM address; bg_data in COL_W background ROM data; spr_addr out clog2(SPR_W*SPR_H) sprite ROM address; spr_data in COL_W sprite ROM data; x out clog2(SCR_W) pixel column; y out clog2(SCR_H) pixel row; colour out COL_W pixel colour; plot out 1 pixel write strobe; busy out 1 frame being drawn; frame_done out 1 frame-complete pulse.
REQ-003 The block SHALL use one clock, clk; resetn SHALL be asynchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, BG, SPR, WAIT, UPDATE; IDLE->BG when start=1; BG->SPR after last background address; SPR->WAIT after last sprite address; WAIT->UPDATE when tick pending; UPDATE->BG unconditionally.
REQ-005 start SHALL be ignored outside IDLE.
REQ-006 BG SHALL issue one address per cycle, raster order col 0..SCR_W-1 then row 0..SCR_H-1; bg_addr = row*BG_W + ((scroll+col) mod BG_W), mod by single subtract (scroll<BG_W invariant).
REQ-007 ROMs have 1-cycle read latency; x, y, plot SHALL be delayed one cycle so colour aligns with its coordinate.
REQ-008 Background pixels SHALL assert plot=1 with colour=bg_data, x=col, y=row.
REQ-009 SPR SHALL scan SPR_W x SPR_H raster; spr_addr=row*SPR_W+col; output x=SPR_X+col, y=GROUND_Y-height+row, colour=spr_data; plot=1 only when spr_data != TRANSP.
REQ-010 frame_done SHALL pulse one cycle on the cycle after the last sprite pixel output (entry to WAIT).
REQ-011 busy SHALL be 1 in BG, SPR, UPDATE; 0 in IDLE, WAIT.
REQ-012 A tick arriving in any non-IDLE state SHALL be latched (single bit, extra ticks merged) and consumed on WAIT->UPDATE; tick in IDLE discarded.
REQ-013 UPDATE SHALL set scroll = scroll+SCROLL_STEP, wrapping to scroll+SCROLL_STEP-BG_W when >= BG_W.
REQ-014 Jump sub-state GROUND/RISE/FALL: jump=1 while GROUND latches request (held until UPDATE); jump while airborne ignored.
REQ-015 In UPDATE: GROUND with request -> RISE, height=1; RISE height+1, ->FALL at JUMP_H; FALL height-1, ->GROUND at 0.
REQ-016 Height SHALL never exceed JUMP_H nor go below 0; scroll and jump update in the same UPDATE cycle.
REQ-017 Elaboration SHALL fail if SPR_X+SPR_W>SCR_W, GROUND_Y+SPR_H>SCR_H, JUMP_H>GROUND_Y, or SCROLL_STEP>=BG_W.

Reset
REQ-018 resetn=0 at any time, including mid-frame, SHALL force IDLE, scroll=0, height=0, jump state GROUND, pending tick/jump cleared, all address counters 0.
REQ-019 Outputs during reset SHALL be plot=0, busy=0, frame_done=0, x=0, y=0, colour=0, bg_addr=0, spr_addr=0.

Structure
REQ-020 A shared package SHALL hold FSM state encoding, jump sub-state encoding and default colour constants (TRANSP).
REQ-021 One sub-module, raster_counter (parametrised W,H; enable, clear, col, row, last), SHALL be instantiated for background and sprite scans.

Verification
REQ-022 Reset, start=1 one cycle -> bg_addr 0,1,...,159 then 2000; first plot one cycle after first address; 19200 BG plots then 240 sprite addresses; frame_done one pulse.
REQ-023 Scroll wrap: force 1999 ticks -> scroll=1999, frame address col 1 row 0 = 0; next tick -> scroll=0.
REQ-024 jump=1 once while grounded, ticks -> sprite top y 23,22,...,4 then back to 24 after 40 ticks; jump during flight ignored.
REQ-025 Sprite ROM word=TRANSP at address 0 -> no plot at (20, GROUND_Y); non-zero word -> plot with that colour.
REQ-026 Three ticks during BG -> exactly one UPDATE after WAIT entry; scroll +1 only.
REQ-027 resetn=0 mid-BG (row 50) -> IDLE, plot=0 immediately; restart redraws from address 0, scroll=0.
